// File: rtl/branch_resolve_predict.sv
// Branch unit for EX: resolves conditional branches, flags mispredictions,
// trains a direct-mapped table of 2-bit counters that predicts for IF, and keeps stats.
module branch_resolve_predict #(
    parameter int WIDTH      = 32,
    parameter int PC_WIDTH   = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    input  logic                  ex_valid,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [2:0]            ex_cond,
    input  logic [WIDTH-1:0]      ex_in1,
    input  logic [WIDTH-1:0]      ex_in2,
    input  logic                  ex_pred_taken,
    output logic                  branch_taken,
    output logic                  mispredict,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int IDX = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        COND_NONE = 3'b000,
        COND_BEQ  = 3'b001,
        COND_BNE  = 3'b010,
        COND_BLEZ = 3'b011,
        COND_BGTZ = 3'b100,
        COND_BLTZ = 3'b101,
        COND_BGEZ = 3'b110,
        COND_RSVD = 3'b111
    } cond_t;

    logic [1:0]            bht_reg  [BHT_DEPTH];
    logic [1:0]            bht_next [BHT_DEPTH];
    logic [IDX-1:0]        if_idx;
    logic [IDX-1:0]        ex_idx;
    logic [1:0]            ex_entry;
    logic [1:0]            ex_entry_upd;
    logic                  is_br;
    logic                  cond_hold;
    logic                  ops_equal;
    logic                  in1_neg;
    logic                  in1_zero;
    logic [STAT_WIDTH-1:0] stat_branches_reg;
    logic [STAT_WIDTH-1:0] stat_mispredicts_reg;
    logic [STAT_WIDTH-1:0] stat_branches_next;
    logic [STAT_WIDTH-1:0] stat_mispredicts_next;

    assign if_idx    = if_pc[IDX+1:2];
    assign ex_idx    = ex_pc[IDX+1:2];
    assign ops_equal = (ex_in1 == ex_in2);
    assign in1_neg   = ex_in1[WIDTH-1];
    assign in1_zero  = (ex_in1 == '0);

    always_comb begin
        cond_hold = 1'b0;
        is_br     = 1'b0;
        case (cond_t'(ex_cond))
            COND_BEQ:  begin is_br = ex_valid; cond_hold = ops_equal;             end
            COND_BNE:  begin is_br = ex_valid; cond_hold = !ops_equal;            end
            COND_BLEZ: begin is_br = ex_valid; cond_hold = in1_neg || in1_zero;   end
            COND_BGTZ: begin is_br = ex_valid; cond_hold = !in1_neg && !in1_zero; end
            COND_BLTZ: begin is_br = ex_valid; cond_hold = in1_neg;               end
            COND_BGEZ: begin is_br = ex_valid; cond_hold = !in1_neg;              end
            default:   begin is_br = 1'b0;     cond_hold = 1'b0;                  end
        endcase
    end

    assign branch_taken = is_br && cond_hold;
    assign mispredict   = is_br && (branch_taken != ex_pred_taken);

    // IF reads the registered table directly, so a same-cycle update is seen next cycle.
    assign pred_taken = bht_reg[if_idx][1];

    assign ex_entry = bht_reg[ex_idx];
    always_comb begin
        ex_entry_upd = ex_entry;
        if (branch_taken) begin
            if (ex_entry != 2'b11) ex_entry_upd = ex_entry + 2'b01;
        end else begin
            if (ex_entry != 2'b00) ex_entry_upd = ex_entry - 2'b01;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            assign bht_next[gi] = (is_br && ex_idx == IDX'(gi)) ? ex_entry_upd : bht_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_reg[i] <= 2'b01;
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_reg[i] <= bht_next[i];
        end
    end

    // Clear wins over any increment in the same cycle.
    always_comb begin
        stat_branches_next    = stat_branches_reg;
        stat_mispredicts_next = stat_mispredicts_reg;
        if (stat_clear) begin
            stat_branches_next    = '0;
            stat_mispredicts_next = '0;
        end else begin
            if (is_br && stat_branches_reg != '1)
                stat_branches_next = stat_branches_reg + 1'b1;
            if (mispredict && stat_mispredicts_reg != '1)
                stat_mispredicts_next = stat_mispredicts_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            stat_branches_reg    <= stat_branches_next;
            stat_mispredicts_reg <= stat_mispredicts_next;
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: resolution sweep, counter training,
// aliasing/collision, statistics saturation/clear and asynchronous reset.
module tb_branch_resolve_predict;
    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_cond;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic        ex_pred_taken;
    logic        branch_taken;
    logic        mispredict;
    logic        stat_clear;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int checks;
    int fails;

    branch_resolve_predict #(
        .WIDTH(32), .PC_WIDTH(32), .BHT_DEPTH(16), .STAT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_cond(ex_cond),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_pred_taken(ex_pred_taken),
        .branch_taken(branch_taken), .mispredict(mispredict),
        .stat_clear(stat_clear), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one EX-stage slot right after a falling edge; outputs settle by #1.
    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [2:0] c,
                            input logic [31:0] a, input logic [31:0] b, input logic p);
        @(negedge clk);
        ex_valid = v; ex_pc = pc; ex_cond = c; ex_in1 = a; ex_in2 = b; ex_pred_taken = p;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_pc = 32'h40; ex_valid = 1'b0; ex_pc = '0; ex_cond = '0;
        ex_in1 = '0; ex_in2 = '0; ex_pred_taken = 1'b0; stat_clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred: got %0b expected 0", pred_taken); end
        checks++; if (stat_branches !== 4'd0) begin fails++; $display("FAIL reset_branches: got %0d expected 0", stat_branches); end
        checks++; if (stat_mispredicts !== 4'd0) begin fails++; $display("FAIL reset_mispredicts: got %0d expected 0", stat_mispredicts); end
        if_pc = 32'h1234_5678; #1;
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_any: got %0b expected 0", pred_taken); end
        $display("reset: pred=%0b br=%0d mp=%0d", pred_taken, stat_branches, stat_mispredicts);
    endtask

    task automatic test_cond_sweep();
        logic [2:0]  conds [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd3, 3'd6, 3'd4};
        logic [31:0] in1s  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        logic        exps  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive_ex(1'b1, 32'h3C, conds[i], in1s[i], 32'hFFFF_FFFF, 1'b0);
            checks++; if (branch_taken !== exps[i]) begin fails++;
                $display("FAIL sweep_taken[%0d]: got %0b expected %0b", i, branch_taken, exps[i]); end
            checks++; if (mispredict !== exps[i]) begin fails++;
                $display("FAIL sweep_mispredict[%0d]: got %0b expected %0b", i, mispredict, exps[i]); end
            $display("sweep cond=%0d in1=%08h taken=%0b mp=%0b", conds[i], in1s[i], branch_taken, mispredict);
        end
        // Non-branch codes never mispredict even when prediction says taken.
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, 32'h3C, (i == 0) ? 3'd0 : 3'd7, 32'h5, 32'h5, 1'b1);
            checks++; if (branch_taken !== 1'b0) begin fails++; $display("FAIL nonbr_taken[%0d]: got %0b expected 0", i, branch_taken); end
            checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL nonbr_mispredict[%0d]: got %0b expected 0", i, mispredict); end
            $display("nonbranch cond=%0d taken=%0b mp=%0b", ex_cond, branch_taken, mispredict);
        end
        drive_ex(1'b0, 32'h3C, 3'd1, 32'h5, 32'h5, 1'b1);
        checks++; if (branch_taken !== 1'b0) begin fails++; $display("FAIL invalid_taken: got %0b expected 0", branch_taken); end
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL invalid_mispredict: got %0b expected 0", mispredict); end
        drive_ex(1'b1, 32'h3C, 3'd1, 32'h5, 32'h5, 1'b1);
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL correct_pred: got %0b expected 0", mispredict); end
        $display("valid/pred: taken=%0b mp=%0b", branch_taken, mispredict);
    endtask

    task automatic test_training();
        // cond, in1, pred -> expected mispredict, expected pred_taken before the edge
        logic [2:0] conds [5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        logic       preds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_mp[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       exp_pt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        if_pc = 32'h40;
        for (int i = 0; i < 5; i++) begin
            drive_ex(1'b1, 32'h40, conds[i], 32'h7, 32'h7, preds[i]);
            checks++; if (mispredict !== exp_mp[i]) begin fails++;
                $display("FAIL train_mispredict[%0d]: got %0b expected %0b", i, mispredict, exp_mp[i]); end
            checks++; if (pred_taken !== exp_pt[i]) begin fails++;
                $display("FAIL train_pred[%0d]: got %0b expected %0b", i, pred_taken, exp_pt[i]); end
            $display("train step=%0d taken=%0b mp=%0b pred=%0b", i, branch_taken, mispredict, pred_taken);
        end
        drive_ex(1'b0, 32'h40, 3'd0, 32'h0, 32'h0, 1'b0);
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL train_final_pred: got %0b expected 0", pred_taken); end
        $display("train final pred=%0b", pred_taken);
    endtask

    task automatic test_alias();
        if_pc = 32'h44;
        drive_ex(1'b1, 32'h04, 3'd1, 32'h1, 32'h1, 1'b0);
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL alias_same_cycle: got %0b expected 0", pred_taken); end
        @(posedge clk); #1;
        checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL alias_next_cycle: got %0b expected 1", pred_taken); end
        ex_valid = 1'b0;
        if_pc = 32'h08; #1;
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL alias_neighbor: got %0b expected 0", pred_taken); end
        if_pc = 32'h04; #1;
        checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL alias_exact_pc: got %0b expected 1", pred_taken); end
        $display("alias: idx1 pred=%0b", pred_taken);
    endtask

    task automatic test_stats();
        @(negedge clk);
        stat_clear = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h3C; ex_cond = 3'd1; ex_in1 = 32'h2; ex_in2 = 32'h2; ex_pred_taken = 1'b0;
        @(negedge clk);
        stat_clear = 1'b0; ex_valid = 1'b0; #1;
        checks++; if (stat_branches !== 4'd0) begin fails++; $display("FAIL clear_branches: got %0d expected 0", stat_branches); end
        checks++; if (stat_mispredicts !== 4'd0) begin fails++; $display("FAIL clear_mispredicts: got %0d expected 0", stat_mispredicts); end
        $display("clear: br=%0d mp=%0d", stat_branches, stat_mispredicts);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stat_branches !== 4'd0) begin fails++; $display("FAIL idle_branches: got %0d expected 0", stat_branches); end
        for (int i = 0; i < 20; i++) begin
            drive_ex(1'b1, 32'h3C, 3'd1, 32'h2, 32'h2, (i < 3) ? 1'b0 : 1'b1);
            if (i == 5) begin
                checks++; if (stat_branches !== 4'd5) begin fails++; $display("FAIL count_branches: got %0d expected 5", stat_branches); end
                checks++; if (stat_mispredicts !== 4'd3) begin fails++; $display("FAIL count_mispredicts: got %0d expected 3", stat_mispredicts); end
            end
        end
        drive_ex(1'b0, 32'h3C, 3'd1, 32'h2, 32'h2, 1'b0);
        checks++; if (stat_branches !== 4'd15) begin fails++; $display("FAIL sat_branches: got %0d expected 15", stat_branches); end
        checks++; if (stat_mispredicts !== 4'd3) begin fails++; $display("FAIL sat_mispredicts: got %0d expected 3", stat_mispredicts); end
        $display("saturate: br=%0d mp=%0d", stat_branches, stat_mispredicts);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stat_branches !== 4'd15) begin fails++; $display("FAIL idle_hold: got %0d expected 15", stat_branches); end
        @(negedge clk);
        stat_clear = 1'b1;
        ex_valid = 1'b1; ex_cond = 3'd2; ex_pred_taken = 1'b0; ex_in1 = 32'h1; ex_in2 = 32'h3;
        @(negedge clk);
        stat_clear = 1'b0; ex_valid = 1'b0; #1;
        checks++; if (stat_branches !== 4'd0) begin fails++; $display("FAIL clear_override_br: got %0d expected 0", stat_branches); end
        checks++; if (stat_mispredicts !== 4'd0) begin fails++; $display("FAIL clear_override_mp: got %0d expected 0", stat_mispredicts); end
        $display("clear with branch: br=%0d mp=%0d", stat_branches, stat_mispredicts);
    endtask

    task automatic test_async_reset();
        if_pc = 32'h44;
        drive_ex(1'b1, 32'h3C, 3'd1, 32'h9, 32'h9, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; #1;
        checks++; if (stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin fails++;
            $display("FAIL pre_reset_stats: got %0d/%0d expected 1/1", stat_branches, stat_mispredicts); end
        checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL pre_reset_pred: got %0b expected 1", pred_taken); end
        #1;
        rst = 1'b1;
        ex_valid = 1'b1; ex_cond = 3'd1; ex_in1 = 32'h9; ex_in2 = 32'h9; ex_pred_taken = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL async_pred: got %0b expected 0", pred_taken); end
        checks++; if (stat_branches !== 4'd0) begin fails++; $display("FAIL async_branches: got %0d expected 0", stat_branches); end
        checks++; if (stat_mispredicts !== 4'd0) begin fails++; $display("FAIL async_mispredicts: got %0d expected 0", stat_mispredicts); end
        checks++; if (branch_taken !== 1'b1 || mispredict !== 1'b1) begin fails++;
            $display("FAIL async_comb: got %0b/%0b expected 1/1", branch_taken, mispredict); end
        $display("async reset: pred=%0b br=%0d mp=%0d taken=%0b", pred_taken, stat_branches, stat_mispredicts, branch_taken);
        @(negedge clk);
        ex_valid = 1'b0; rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_cond_sweep();
        test_training();
        test_alias();
        test_stats();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised branch unit for the pipelined MIPS core. It resolves an extended set of conditional branches in EX using equality and signed-zero tests. It also holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that feeds a taken/not-taken prediction to IF. It flags mispredictions for the hazard/flush logic and keeps saturating branch and mispredict statistics counters.

## Interface
Parameters:
- WIDTH, 32, operand width of in1/in2.
- PC_WIDTH, 32, program counter width.
- BHT_DEPTH, 16, number of BHT entries; power of two, ≥2; index width IDX = log2(BHT_DEPTH).
- STAT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  PC_WIDTH  PC of the instruction being fetched.
- pred_taken  out  1  prediction for if_pc; combinational from BHT.
- ex_valid  in  1  EX stage holds a valid, non-stalled instruction.
- ex_pc  in  PC_WIDTH  PC of the EX instruction.
- ex_cond  in  3  branch condition code (see Operation).
- ex_in1, ex_in2  in  WIDTH  forwarded rs and rt operands.
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- branch_taken  out  1  resolved outcome; combinational.
- mispredict  out  1  resolved outcome differs from ex_pred_taken; combinational.
- stat_clear  in  1  synchronous clear of both statistics counters.
- stat_branches  out  STAT_WIDTH  count of resolved branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredictions.

## Operation
- ex_cond encoding and branch test:
  - 000: not a branch.
  - 001: beq, in1 == in2.
  - 010: bne, in1 != in2.
  - 011: blez, signed in1 ≤ 0.
  - 100: bgtz, signed in1 > 0.
  - 101: bltz, in1[WIDTH-1] == 1.
  - 110: bgez, in1[WIDTH-1] == 0.
  - 111: reserved, treated as not a branch.
- is_br = ex_valid and ex_cond is in 001..110.
- branch_taken = is_br and the test for ex_cond holds; 0 otherwise.
- mispredict = is_br and (branch_taken != ex_pred_taken). It is 0 whenever is_br = 0, regardless of ex_pred_taken.
- BHT index = pc[IDX+1:2] for both if_pc and ex_pc; the word-aligned low 2 bits are ignored. There are no tags, so aliasing is accepted.
- pred_taken = MSB of the entry at the if_pc index.
- Counter states:
  - 00: strong not-taken (SN).
  - 01: weak not-taken (WN).
  - 10: weak taken (WT).
  - 11: strong taken (ST).
- Counter update, only on a clock edge with is_br = 1:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - All other entries hold.
- Statistics:
  - stat_branches increments on each edge with is_br = 1.
  - stat_mispredicts increments on each edge with mispredict = 1.
  - Both saturate at all-ones and hold there.
  - stat_clear = 1 forces both to 0 at the next edge and overrides any same-cycle increment.

## Timing
- Reset (async, immediate): every BHT entry = 01 (WN), so pred_taken = 0 after reset. Both stat counters = 0.
- branch_taken and mispredict are combinational from EX inputs; they are valid in the same cycle, with no registered latency.
- A BHT update is visible on pred_taken from the cycle after the resolving edge.
- Same-cycle IF read and EX write to the same index: IF sees the pre-update value. There is no write-to-read bypass.
- ex_valid = 0 (stall or bubble): no BHT or stat change, and both resolution outputs are 0.
- Reset asserted mid-operation: the table and counters return to reset values immediately. Outputs derived from EX inputs stay combinational.
- Stat counters are registered outputs that change only on clock edges or reset.

## Test plan
- Reset, then any if_pc -> pred_taken = 0; stat_branches = stat_mispredicts = 0.
- Condition sweep with ex_valid = 1 and in1 = 0xFFFFFFFF (−1), in2 = 0xFFFFFFFF:
  - beq -> taken; bne -> not taken.
  - blez -> taken; bgtz -> not taken.
  - bltz -> taken; bgez -> not taken.
  - Repeat with in1 = 0: blez -> taken, bgez -> taken, bgtz -> not taken.
  - ex_cond 000 or 111 -> branch_taken = 0, mispredict = 0.
- Counter training at ex_pc = 0x40:
  - Taken beq twice with ex_pred_taken = 0 -> mispredict = 1 on both.
  - Entry goes 01→10→11; pred_taken for if_pc = 0x40 becomes 1 one cycle after the first edge.
  - A third taken beq keeps the entry at 11.
  - Two not-taken branches -> entry 11→10→01; pred_taken = 0 after the second.
- Aliasing and collision with BHT_DEPTH = 16: ex_pc = 0x04 and if_pc = 0x44 share index 1.
  - A same-cycle update leaves pred_taken at its old value that cycle and shows the new value next cycle.
  - Index 2 (if_pc = 0x08) is unchanged.
- Statistics with STAT_WIDTH = 4:
  - 20 resolved branches -> stat_branches saturates at 15.
  - stat_clear together with a mispredicting branch -> both counters 0 the next cycle.
  - ex_valid = 0 cycles -> no change.
- Asynchronous reset asserted mid-cycle after training -> pred_taken drops to 0 and stats read 0 before the next clk edge.
